// File: rtl/sdram_arb_pkg.sv
// Shared types and default constants for the three-port SDRAM arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    PORT_V = 2'd0,
    PORT_C = 2'd1,
    PORT_L = 2'd2
  } port_id_t;

  localparam int ADDR_W_DEF        = 18;
  localparam int ACCESS_CYCLES_DEF = 4;
  localparam int STARVE_LIMIT_DEF  = 8;

endpackage

// File: rtl/sdram_arb_prio.sv
// Combinational winner selection (V > C > L, loader forced in once starved)
// together with the next value of the loader starvation counter.
module sdram_arb_prio
  import sdram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int SC_W         = $clog2(STARVE_LIMIT + 1)
) (
  input  logic            v_req_i,
  input  logic            c_req_i,
  input  logic            l_req_i,
  input  logic [SC_W-1:0] starve_cnt_i,
  output logic            grant_valid_o,
  output port_id_t        grant_o,
  output logic [SC_W-1:0] starve_cnt_o
);

  logic any_s;
  logic starved_s;

  assign any_s     = v_req_i | c_req_i | l_req_i;
  assign starved_s = (starve_cnt_i == SC_W'(STARVE_LIMIT));

  // Winner pick and counter update; counter only moves when a grant is made
  always_comb begin
    grant_valid_o = any_s;
    grant_o       = PORT_V;
    starve_cnt_o  = starve_cnt_i;
    if (l_req_i && starved_s) begin
      grant_o = PORT_L;
    end else if (v_req_i) begin
      grant_o = PORT_V;
    end else if (c_req_i) begin
      grant_o = PORT_C;
    end else if (l_req_i) begin
      grant_o = PORT_L;
    end else begin
      grant_o = PORT_V;
    end

    if (!any_s) begin
      starve_cnt_o = starve_cnt_i;
    end else if ((grant_o == PORT_L) || !l_req_i) begin
      starve_cnt_o = {SC_W{1'b0}};
    end else if (starved_s) begin
      starve_cnt_o = starve_cnt_i;
    end else begin
      starve_cnt_o = starve_cnt_i + SC_W'(1);
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one ssdram byte port between video, CPU and loader requesters.
// Optional per-port grant statistics are enabled with SDRAM_ARB_STATS_EN.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
  parameter int STARVE_LIMIT  = STARVE_LIMIT_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              v_req,
  input  logic [ADDR_W-1:0] v_addr,
  output logic              v_ack,
  output logic [7:0]        v_rdata,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [7:0]        c_wdata,
  output logic              c_ack,
  output logic [7:0]        c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [7:0]        l_wdata,
  output logic              l_ack,
  output logic [7:0]        l_rdata,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_data_o,
  input  logic [7:0]        ram_data_i,
  output logic              ram_cs_o,
  output logic              ram_oe_o,
  output logic              ram_we_o,
  output logic              busy
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [15:0]       v_grants,
  output logic [15:0]       c_grants,
  output logic [15:0]       l_grants,
  output logic              l_starved
`endif
);

  localparam int          SC_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [3:0]  CYC_LOAD = 4'(ACCESS_CYCLES - 1);

  arb_state_t        state_q, state_d;
  port_id_t          winner_q, winner_d, grant_s;
  logic              grant_valid_s;
  logic [SC_W-1:0]   starve_q, starve_d, starve_nxt_s;
  logic [3:0]        cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        v_rdata_q, v_rdata_d, c_rdata_q, c_rdata_d, l_rdata_q, l_rdata_d;
  logic              cs_q, cs_d, oe_q, oe_d, wes_q, wes_d, busy_q, busy_d;
  logic              v_ack_q, v_ack_d, c_ack_q, c_ack_d, l_ack_q, l_ack_d;

  sdram_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .SC_W         (SC_W)
  ) u_prio (
    .v_req_i       (v_req),
    .c_req_i       (c_req),
    .l_req_i       (l_req),
    .starve_cnt_i  (starve_q),
    .grant_valid_o (grant_valid_s),
    .grant_o       (grant_s),
    .starve_cnt_o  (starve_nxt_s)
  );

  // Next-state, latched request fields, read capture and registered strobes
  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    starve_d  = starve_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    v_rdata_d = v_rdata_q;
    c_rdata_d = c_rdata_q;
    l_rdata_d = l_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          state_d  = ACCESS;
          winner_d = grant_s;
          starve_d = starve_nxt_s;
          cyc_d    = CYC_LOAD;
          case (grant_s)
            PORT_C: begin
              addr_d  = c_addr;
              wdata_d = c_wdata;
              we_d    = c_we;
            end
            PORT_L: begin
              addr_d  = l_addr;
              wdata_d = l_wdata;
              we_d    = l_we;
            end
            default: begin
              addr_d = v_addr;
              we_d   = 1'b0;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cyc_q == 4'd0) begin
          state_d = ACK;
          if (!we_q) begin
            case (winner_q)
              PORT_V:  v_rdata_d = ram_data_i;
              PORT_C:  c_rdata_d = ram_data_i;
              PORT_L:  l_rdata_d = ram_data_i;
              default: v_rdata_d = v_rdata_q;
            endcase
          end else begin
            v_rdata_d = v_rdata_q;
          end
        end else begin
          cyc_d = cyc_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cs_d    = (state_d == ACCESS);
    oe_d    = cs_d & ~we_d;
    wes_d   = cs_d & we_d;
    busy_d  = (state_d != IDLE);
    v_ack_d = (state_d == ACK) && (winner_d == PORT_V);
    c_ack_d = (state_d == ACK) && (winner_d == PORT_C);
    l_ack_d = (state_d == ACK) && (winner_d == PORT_L);
  end

  // State and output registers; reset abandons any in-flight access
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      winner_q  <= PORT_V;
      starve_q  <= {SC_W{1'b0}};
      cyc_q     <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= 8'h00;
      v_rdata_q <= 8'h00;
      c_rdata_q <= 8'h00;
      l_rdata_q <= 8'h00;
      cs_q      <= 1'b0;
      oe_q      <= 1'b0;
      wes_q     <= 1'b0;
      busy_q    <= 1'b0;
      v_ack_q   <= 1'b0;
      c_ack_q   <= 1'b0;
      l_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      starve_q  <= starve_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      v_rdata_q <= v_rdata_d;
      c_rdata_q <= c_rdata_d;
      l_rdata_q <= l_rdata_d;
      cs_q      <= cs_d;
      oe_q      <= oe_d;
      wes_q     <= wes_d;
      busy_q    <= busy_d;
      v_ack_q   <= v_ack_d;
      c_ack_q   <= c_ack_d;
      l_ack_q   <= l_ack_d;
    end
  end

  assign ram_addr_o = addr_q;
  assign ram_data_o = wdata_q;
  assign ram_cs_o   = cs_q;
  assign ram_oe_o   = oe_q;
  assign ram_we_o   = wes_q;
  assign busy       = busy_q;
  assign v_ack      = v_ack_q;
  assign c_ack      = c_ack_q;
  assign l_ack      = l_ack_q;
  assign v_rdata    = v_rdata_q;
  assign c_rdata    = c_rdata_q;
  assign l_rdata    = l_rdata_q;

`ifdef SDRAM_ARB_STATS_EN
  logic [15:0] v_grants_q, c_grants_q, l_grants_q;
  logic        l_starved_q;

  // Wrap-around ack counters, counted on the same edge the ack appears
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      v_grants_q  <= 16'd0;
      c_grants_q  <= 16'd0;
      l_grants_q  <= 16'd0;
      l_starved_q <= 1'b0;
    end else begin
      v_grants_q  <= v_grants_q + {15'd0, v_ack_d};
      c_grants_q  <= c_grants_q + {15'd0, c_ack_d};
      l_grants_q  <= l_grants_q + {15'd0, l_ack_d};
      l_starved_q <= (starve_d == SC_W'(STARVE_LIMIT));
    end
  end

  assign v_grants  = v_grants_q;
  assign c_grants  = c_grants_q;
  assign l_grants  = l_grants_q;
  assign l_starved = l_starved_q;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus a
// randomized run checked against a phase-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

  localparam int AW = 18;
  localparam int AC = 4;
  localparam int SL = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          v_req, c_req, c_we, l_req, l_we;
  logic [AW-1:0] v_addr, c_addr, l_addr;
  logic [7:0]    c_wdata, l_wdata;
  logic          v_ack, c_ack, l_ack;
  logic [7:0]    v_rdata, c_rdata, l_rdata;
  logic [AW-1:0] ram_addr_o;
  logic [7:0]    ram_data_o, ram_data_i, ram_data_drv;
  logic          ram_cs_o, ram_oe_o, ram_we_o, busy;
  logic          use_hash;
`ifdef SDRAM_ARB_STATS_EN
  logic [15:0]   v_grants, c_grants, l_grants;
  logic          l_starved;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  function automatic logic [7:0] hash8(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'h5C;
  endfunction

  assign ram_data_i = use_hash ? hash8(ram_addr_o) : ram_data_drv;

  sdram_port_arbiter #(.ADDR_W(AW), .ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset_n(reset_n),
    .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack), .v_rdata(v_rdata),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_rdata(l_rdata),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
    .ram_cs_o(ram_cs_o), .ram_oe_o(ram_oe_o), .ram_we_o(ram_we_o), .busy(busy)
`ifdef SDRAM_ARB_STATS_EN
    , .v_grants(v_grants), .c_grants(c_grants), .l_grants(l_grants), .l_starved(l_starved)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; use_hash = 1'b0; ram_data_drv = 8'h00;
    v_req = 1'b0; v_addr = '0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = 8'h00;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = 8'h00;
    tick(); tick();
    total++;
    if ({ram_cs_o, ram_oe_o, ram_we_o, busy} !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes got=%b exp=0000", {ram_cs_o, ram_oe_o, ram_we_o, busy});
    end
    total++;
    if ({v_ack, c_ack, l_ack} !== 3'b000) begin
      bad++; $display("FAIL reset_acks got=%b exp=000", {v_ack, c_ack, l_ack});
    end
    total++;
    if ({v_rdata, c_rdata, l_rdata} !== 24'h000000) begin
      bad++; $display("FAIL reset_rdata got=%h exp=000000", {v_rdata, c_rdata, l_rdata});
    end
    total++;
    if ({ram_addr_o, ram_data_o} !== 26'h0) begin
      bad++; $display("FAIL reset_addr_data got=%h exp=0", {ram_addr_o, ram_data_o});
    end
    reset_n = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_single_read();
    c_req = 1'b1; c_we = 1'b0; c_addr = 18'h01234; ram_data_drv = 8'hA5;
    tick();
    for (int i = 1; i <= AC; i++) begin
      total++;
      if ({ram_cs_o, ram_oe_o, ram_we_o, busy, c_ack} !== 5'b11010 || ram_addr_o !== 18'h01234) begin
        bad++; $display("FAIL rd_access cyc=%0d got cs/oe/we/busy/ack=%b addr=%h exp 11010 addr=01234",
                        i, {ram_cs_o, ram_oe_o, ram_we_o, busy, c_ack}, ram_addr_o);
      end
      tick();
    end
    total++;
    if ({c_ack, v_ack, l_ack, ram_cs_o} !== 4'b1000 || c_rdata !== 8'hA5) begin
      bad++; $display("FAIL rd_ack got ack/cs=%b rdata=%h exp 1000 rdata=a5",
                      {c_ack, v_ack, l_ack, ram_cs_o}, c_rdata);
    end
    c_req = 1'b0;
    tick();
    total++;
    if (c_ack !== 1'b0 || busy !== 1'b0 || c_rdata !== 8'hA5) begin
      bad++; $display("FAIL rd_after got ack=%b busy=%b rdata=%h exp 0 0 a5", c_ack, busy, c_rdata);
    end
  endtask

  task automatic test_write();
    tick();
    l_req = 1'b1; l_we = 1'b1; l_addr = 18'h3FFFF; l_wdata = 8'h5A; ram_data_drv = 8'hFF;
    tick();
    for (int i = 1; i <= AC; i++) begin
      total++;
      if ({ram_cs_o, ram_oe_o, ram_we_o} !== 3'b101 || ram_data_o !== 8'h5A || ram_addr_o !== 18'h3FFFF) begin
        bad++; $display("FAIL wr_access cyc=%0d got cs/oe/we=%b data=%h addr=%h exp 101 5a 3ffff",
                        i, {ram_cs_o, ram_oe_o, ram_we_o}, ram_data_o, ram_addr_o);
      end
      tick();
    end
    total++;
    if (l_ack !== 1'b1 || l_rdata !== 8'h00 || c_rdata !== 8'hA5) begin
      bad++; $display("FAIL wr_ack got ack=%b l_rdata=%h c_rdata=%h exp 1 00 a5", l_ack, l_rdata, c_rdata);
    end
    l_req = 1'b0; l_we = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    int seen;
    int order[3];
    int at[3];
    tick();
    seen = 0;
    v_req = 1'b1; v_addr = 18'h00100;
    c_req = 1'b1; c_we = 1'b0; c_addr = 18'h00200;
    l_req = 1'b1; l_we = 1'b0; l_addr = 18'h00300;
    ram_data_drv = 8'h11;
    for (int cyc = 1; cyc <= 40 && seen < 3; cyc++) begin
      tick();
      total++;
      if (int'(v_ack) + int'(c_ack) + int'(l_ack) > 1) begin
        bad++; $display("FAIL sim_onehot cyc=%0d got=%b exp at most one", cyc, {v_ack, c_ack, l_ack});
      end
      if (v_ack) begin order[seen] = 0; at[seen] = cyc; seen++; v_req = 1'b0; end
      else if (c_ack) begin order[seen] = 1; at[seen] = cyc; seen++; c_req = 1'b0; end
      else if (l_ack) begin order[seen] = 2; at[seen] = cyc; seen++; l_req = 1'b0; end
    end
    v_req = 1'b0; c_req = 1'b0; l_req = 1'b0;
    total++;
    if (seen != 3) begin
      bad++; $display("FAIL sim_count got=%0d exp=3", seen);
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (order[k] != k || at[k] != 5 + 6 * k) begin
          bad++; $display("FAIL sim_order k=%0d got port=%0d cyc=%0d exp port=%0d cyc=%0d",
                          k, order[k], at[k], k, 5 + 6 * k);
        end
      end
    end
    tick();
  endtask

  task automatic test_starvation();
    int log_q[$];
    tick();
    v_req = 1'b1; v_addr = 18'h00010;
    c_req = 1'b1; c_we = 1'b0; c_addr = 18'h00020;
    l_req = 1'b1; l_we = 1'b0; l_addr = 18'h00030;
    ram_data_drv = 8'h22;
    for (int cyc = 0; cyc < 300 && log_q.size() < 18; cyc++) begin
      tick();
      if (v_ack) log_q.push_back(0);
      else if (c_ack) log_q.push_back(1);
      else if (l_ack) log_q.push_back(2);
    end
    v_req = 1'b0; c_req = 1'b0; l_req = 1'b0;
    total++;
    if (log_q.size() != 18) begin
      bad++; $display("FAIL starve_count got=%0d exp=18", log_q.size());
    end
    for (int k = 0; k < log_q.size(); k++) begin
      total++;
      if (log_q[k] != ((k == 8 || k == 17) ? 2 : 0)) begin
        bad++; $display("FAIL starve_order k=%0d got=%0d exp=%0d", k, log_q[k], (k == 8 || k == 17) ? 2 : 0);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    int ack_at;
    tick();
    ack_at = 0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 18'h0ABCD; ram_data_drv = 8'h77;
    tick();
    tick();
    total++;
    if (ram_cs_o !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre got cs=%b exp=1", ram_cs_o);
    end
    reset_n = 1'b0;
    tick();
    total++;
    if ({ram_cs_o, ram_oe_o, ram_we_o, busy, v_ack, c_ack, l_ack} !== 7'b0 || c_rdata !== 8'h00) begin
      bad++; $display("FAIL rst_mid_abort got strobes/busy/acks=%b c_rdata=%h exp 0000000 00",
                      {ram_cs_o, ram_oe_o, ram_we_o, busy, v_ack, c_ack, l_ack}, c_rdata);
    end
    reset_n = 1'b1;
    for (int cyc = 1; cyc <= 20 && ack_at == 0; cyc++) begin
      tick();
      if (cyc == 1) begin
        total++;
        if (ram_cs_o !== 1'b1 || ram_addr_o !== 18'h0ABCD) begin
          bad++; $display("FAIL rst_mid_regrant got cs=%b addr=%h exp 1 0abcd", ram_cs_o, ram_addr_o);
        end
      end
      if (c_ack) ack_at = cyc;
    end
    total++;
    if (ack_at != AC + 1 || c_rdata !== 8'h77) begin
      bad++; $display("FAIL rst_mid_ack got cyc=%0d rdata=%h exp cyc=%0d rdata=77", ack_at, c_rdata, AC + 1);
    end
    c_req = 1'b0;
    tick();
  endtask

  task automatic test_video_read();
    tick();
    v_req = 1'b1; v_addr = 18'h01111; c_we = 1'b1; l_we = 1'b1; c_wdata = 8'hEE;
    ram_data_drv = 8'h3C;
    tick();
    for (int i = 1; i <= AC; i++) begin
      total++;
      if ({ram_cs_o, ram_oe_o, ram_we_o} !== 3'b110) begin
        bad++; $display("FAIL vid_access cyc=%0d got cs/oe/we=%b exp=110", i, {ram_cs_o, ram_oe_o, ram_we_o});
      end
      tick();
    end
    total++;
    if (v_ack !== 1'b1 || v_rdata !== 8'h3C) begin
      bad++; $display("FAIL vid_ack got ack=%b rdata=%h exp 1 3c", v_ack, v_rdata);
    end
`ifdef SDRAM_ARB_STATS_EN
    total++;
    if (v_grants !== 16'd1 || c_grants !== 16'd1 || l_grants !== 16'd0) begin
      bad++; $display("FAIL vid_stats got v=%0d c=%0d l=%0d exp 1 1 0", v_grants, c_grants, l_grants);
    end
`endif
    v_req = 1'b0; c_we = 1'b0; l_we = 1'b0;
    tick();
  endtask

  logic          r_req[3];
  logic          r_we[3];
  logic [AW-1:0] r_addr[3];
  logic [7:0]    r_wd[3];

  task automatic drive_arrays();
    v_req = r_req[0]; v_addr = r_addr[0];
    c_req = r_req[1]; c_we = r_we[1]; c_addr = r_addr[1]; c_wdata = r_wd[1];
    l_req = r_req[2]; l_we = r_we[2]; l_addr = r_addr[2]; l_wdata = r_wd[2];
  endtask

  task automatic test_random();
    int phase, starve, w;
    logic m_we;
    logic [AW-1:0] m_addr;
    logic [7:0] m_wd;
    logic [7:0] m_rd[3];
    int grants[3];
    int prob[3];
    logic exp_cs, exp_ack;
    logic [2:0] exp_ackv;
    phase = 0; starve = 0; w = 0; m_we = 1'b0; m_addr = '0; m_wd = 8'h00;
    prob[0] = 30; prob[1] = 45; prob[2] = 55;
    for (int p = 0; p < 3; p++) begin
      r_req[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = '0; r_wd[p] = 8'h00;
      m_rd[p] = 8'h00; grants[p] = 0;
    end
    drive_arrays();
    use_hash = 1'b1;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      if (phase == 0) begin
        if (r_req[0] || r_req[1] || r_req[2]) begin
          if (r_req[2] && starve == SL) w = 2;
          else if (r_req[0]) w = 0;
          else if (r_req[1]) w = 1;
          else w = 2;
          if (w == 2 || !r_req[2]) starve = 0;
          else if (starve < SL) starve++;
          m_addr = r_addr[w];
          m_we = (w == 0) ? 1'b0 : r_we[w];
          m_wd = r_wd[w];
          phase = 1;
        end
      end else if (phase == AC + 1) begin
        phase = 0;
      end else begin
        phase++;
      end
      exp_cs = (phase >= 1 && phase <= AC);
      exp_ack = (phase == AC + 1);
      exp_ackv = exp_ack ? (3'b001 << w) : 3'b000;
      if (exp_ack) begin
        grants[w]++;
        if (!m_we) m_rd[w] = hash8(m_addr);
      end
      total++;
      if ({l_ack, c_ack, v_ack} !== exp_ackv || {ram_cs_o, busy} !== {exp_cs, phase != 0}) begin
        bad++; $display("FAIL rnd_ctrl cyc=%0d got ack=%b cs=%b busy=%b exp ack=%b cs=%b busy=%b",
                        cyc, {l_ack, c_ack, v_ack}, ram_cs_o, busy, exp_ackv, exp_cs, phase != 0);
      end
      total++;
      if ({ram_oe_o, ram_we_o} !== {exp_cs & ~m_we, exp_cs & m_we} ||
          (exp_cs && ram_addr_o !== m_addr) || (exp_cs && m_we && ram_data_o !== m_wd)) begin
        bad++; $display("FAIL rnd_bus cyc=%0d got oe=%b we=%b addr=%h data=%h exp oe=%b we=%b addr=%h data=%h",
                        cyc, ram_oe_o, ram_we_o, ram_addr_o, ram_data_o, exp_cs & ~m_we, exp_cs & m_we, m_addr, m_wd);
      end
      total++;
      if ({v_rdata, c_rdata, l_rdata} !== {m_rd[0], m_rd[1], m_rd[2]}) begin
        bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, {v_rdata, c_rdata, l_rdata},
                        {m_rd[0], m_rd[1], m_rd[2]});
      end
`ifdef SDRAM_ARB_STATS_EN
      total++;
      if (l_starved !== (starve == SL)) begin
        bad++; $display("FAIL rnd_starved cyc=%0d got=%b exp=%b", cyc, l_starved, starve == SL);
      end
`endif
      for (int p = 0; p < 3; p++) begin
        if (exp_ack && w == p) r_req[p] = 1'b0;
        if (!r_req[p] && $urandom_range(0, 99) < prob[p]) begin
          r_req[p]  = 1'b1;
          r_we[p]   = 1'($urandom_range(0, 1));
          r_addr[p] = AW'($urandom());
          r_wd[p]   = 8'($urandom());
        end
      end
      drive_arrays();
    end
`ifdef SDRAM_ARB_STATS_EN
    total++;
    if (v_grants !== 16'(grants[0]) || c_grants !== 16'(grants[1]) || l_grants !== 16'(grants[2])) begin
      bad++; $display("FAIL rnd_stats got v=%0d c=%0d l=%0d exp %0d %0d %0d",
                      v_grants, c_grants, l_grants, grants[0], grants[1], grants[2]);
    end
`endif
    total++;
    if (grants[0] + grants[1] + grants[2] < 50) begin
      bad++; $display("FAIL rnd_progress got=%0d exp>=50", grants[0] + grants[1] + grants[2]);
    end
    for (int p = 0; p < 3; p++) r_req[p] = 1'b0;
    drive_arrays();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid_access();
    test_video_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
